// File: rtl/cw_rbg_sched_if.sv
// Handshake bundle between the beam sorter / RE timing, the sequencer and the
// codeword-selection datapath. master = upstream driver, slave = cw_rbg_sched.
interface cw_rbg_sched_if #(
    parameter int BEAM = 16
);
    logic                i_start;
    logic                i_cw_tvalid;
    logic                i_sym_sop;
    logic [7:0]          i_sym_idx;
    logic                i_data_vld;
    logic [BEAM*8-1:0]   i_beam_idx;
    logic                i_beam_vld;

    logic                o_cw_enable;
    logic [7:0]          o_symb_idx;
    logic                o_symb_clr;
    logic                o_symb_1st;
    logic                o_rbg_load;
    logic [BEAM*8-1:0]   o_beam_idx;
    logic [7:0]          o_rbg_cnt;
    logic                o_ready;
    logic                o_err_timeout;
    logic                o_err_beam_miss;

    modport master (
        output i_start, i_cw_tvalid, i_sym_sop, i_sym_idx, i_data_vld,
               i_beam_idx, i_beam_vld,
        input  o_cw_enable, o_symb_idx, o_symb_clr, o_symb_1st, o_rbg_load,
               o_beam_idx, o_rbg_cnt, o_ready, o_err_timeout, o_err_beam_miss
    );

    modport slave (
        input  i_start, i_cw_tvalid, i_sym_sop, i_sym_idx, i_data_vld,
               i_beam_idx, i_beam_vld,
        output o_cw_enable, o_symb_idx, o_symb_clr, o_symb_1st, o_rbg_load,
               o_beam_idx, o_rbg_cnt, o_ready, o_err_timeout, o_err_beam_miss
    );
endinterface

// File: rtl/cw_rbg_sched.sv
// Codeword-selection sequencer: codeword ROM preload with timeout, then per-symbol
// RBG stepping with a shadowed beam-index vector and a one-cycle-delayed load strobe.
//
// state | meaning
// IDLE  | waiting for first i_start
// LOAD  | preload enabled, waiting for codeword stage to report done
// WAIT  | preload released, waiting for two consecutive done cycles
// RUN   | sequencing symbols / RBGs
// ERR   | preload timed out, waiting for i_start
module cw_rbg_sched #(
    parameter int BEAM     = 16,
    parameter int RBG_CYC  = 48,
    parameter int RBG_NUM  = 68,
    parameter int LOAD_TMO = 255
) (
    input logic           i_clk,
    input logic           i_reset_n,
    cw_rbg_sched_if.slave cw
);
    localparam int              RC_W     = $clog2(RBG_CYC);
    localparam logic [RC_W-1:0] RE_LAST  = RC_W'(RBG_CYC - 1);
    localparam logic [7:0]      RBG_LAST = 8'(RBG_NUM - 1);
    localparam logic [8:0]      TMO_LIM  = 9'(LOAD_TMO);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_WAIT, S_RUN, S_ERR} state_t;

    state_t              state;
    logic [8:0]          tmo_cnt;
    logic [8:0]          tmo_inc;
    logic                tmo_hit;
    logic                tv_seen;
    logic                sym_act;
    logic                beam_seen;
    logic                load_pend;
    logic [RC_W-1:0]     re_cnt;
    logic [BEAM*8-1:0]   shadow;

    assign tmo_inc = (tmo_cnt == 9'h1FF) ? tmo_cnt : tmo_cnt + 9'd1;
    assign tmo_hit = (tmo_inc >= TMO_LIM);

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state              <= S_IDLE;
            tmo_cnt            <= '0;
            tv_seen            <= 1'b0;
            sym_act            <= 1'b0;
            beam_seen          <= 1'b0;
            load_pend          <= 1'b0;
            re_cnt             <= '0;
            shadow             <= '0;
            cw.o_cw_enable     <= 1'b0;
            cw.o_symb_idx      <= '0;
            cw.o_symb_clr      <= 1'b0;
            cw.o_symb_1st      <= 1'b0;
            cw.o_rbg_load      <= 1'b0;
            cw.o_beam_idx      <= '0;
            cw.o_rbg_cnt       <= '0;
            cw.o_ready         <= 1'b0;
            cw.o_err_timeout   <= 1'b0;
            cw.o_err_beam_miss <= 1'b0;
        end else begin
            cw.o_symb_clr <= 1'b0;
            cw.o_rbg_load <= 1'b0;
            load_pend     <= 1'b0;

            if (cw.i_start) begin
                // start/restart from any state aborts symbol work and reruns the preload
                state              <= S_LOAD;
                tmo_cnt            <= '0;
                tv_seen            <= 1'b0;
                sym_act            <= 1'b0;
                beam_seen          <= 1'b0;
                cw.o_cw_enable     <= 1'b1;
                cw.o_ready         <= 1'b0;
                cw.o_symb_1st      <= 1'b0;
                cw.o_err_timeout   <= 1'b0;
                cw.o_err_beam_miss <= 1'b0;
            end else begin
                case (state)
                    S_LOAD: begin
                        tmo_cnt <= tmo_inc;
                        if (tmo_hit) begin
                            state            <= S_ERR;
                            cw.o_cw_enable   <= 1'b0;
                            cw.o_err_timeout <= 1'b1;
                        end else if (cw.i_cw_tvalid) begin
                            state          <= S_WAIT;
                            cw.o_cw_enable <= 1'b0;
                            tv_seen        <= 1'b0;
                        end
                    end

                    S_WAIT: begin
                        tmo_cnt <= tmo_inc;
                        if (tmo_hit) begin
                            state            <= S_ERR;
                            cw.o_err_timeout <= 1'b1;
                        end else if (cw.i_cw_tvalid && tv_seen) begin
                            state      <= S_RUN;
                            cw.o_ready <= 1'b1;
                        end else begin
                            tv_seen <= cw.i_cw_tvalid;
                        end
                    end

                    S_RUN: begin
                        cw.o_rbg_load <= load_pend;

                        if (cw.i_beam_vld) begin
                            shadow    <= cw.i_beam_idx;
                            beam_seen <= 1'b1;
                        end

                        if (cw.i_sym_sop) begin
                            // a new symbol kills any load still in the pipe
                            cw.o_symb_idx <= cw.i_sym_idx;
                            cw.o_symb_clr <= (cw.i_sym_idx == 8'd0);
                            cw.o_symb_1st <= 1'b1;
                            cw.o_rbg_cnt  <= '0;
                            cw.o_rbg_load <= 1'b0;
                            re_cnt        <= '0;
                            sym_act       <= 1'b1;
                            beam_seen     <= cw.i_beam_vld;
                        end else if (sym_act && cw.i_data_vld) begin
                            if (re_cnt == RE_LAST) begin
                                re_cnt <= '0;
                                if (cw.o_rbg_cnt < RBG_LAST) begin
                                    cw.o_beam_idx <= cw.i_beam_vld ? cw.i_beam_idx : shadow;
                                    cw.o_rbg_cnt  <= cw.o_rbg_cnt + 8'd1;
                                    cw.o_symb_1st <= 1'b0;
                                    load_pend     <= 1'b1;
                                    beam_seen     <= 1'b0;
                                    if (!(cw.i_beam_vld || beam_seen))
                                        cw.o_err_beam_miss <= 1'b1;
                                end else begin
                                    sym_act <= 1'b0;
                                end
                            end else begin
                                re_cnt <= re_cnt + 1'b1;
                            end
                        end
                    end

                    S_IDLE, S_ERR: ;

                    default: state <= S_IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_cw_rbg_sched.sv
// Directed bench for cw_rbg_sched: preload table vectors, then hand sequences for
// RBG stepping, beam bypass/miss, symbol abort, full symbol and async reset.
module tb_cw_rbg_sched;
    localparam int BEAM    = 16;
    localparam int RBG_CYC = 48;
    localparam int RBG_NUM = 68;
    localparam int BW      = BEAM * 8;

    logic i_clk;
    logic i_reset_n;
    int   n_chk;
    int   n_err;
    int   load_tot;
    int   base;

    cw_rbg_sched_if #(.BEAM(BEAM)) cw ();

    cw_rbg_sched #(
        .BEAM(BEAM), .RBG_CYC(RBG_CYC), .RBG_NUM(RBG_NUM), .LOAD_TMO(255)
    ) dut (
        .i_clk(i_clk),
        .i_reset_n(i_reset_n),
        .cw(cw.slave)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    initial load_tot = 0;
    always @(negedge i_clk) if (cw.o_rbg_load === 1'b1) load_tot <= load_tot + 1;

    typedef struct {
        int   ncyc;
        logic start;
        logic tvalid;
        logic exp_en;
        logic exp_rdy;
        logic exp_tmo;
    } pre_vec_t;

    pre_vec_t tbl[16];

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic sop(input logic [7:0] idx);
        cw.i_sym_sop = 1'b1;
        cw.i_sym_idx = idx;
        step();
        cw.i_sym_sop = 1'b0;
    endtask

    task automatic drive_re(input int n, input int bv_at, input logic [BW-1:0] bv);
        for (int k = 0; k < n; k++) begin
            cw.i_data_vld = 1'b1;
            cw.i_beam_vld = (bv_at >= 0) && ((k % RBG_CYC) == bv_at);
            cw.i_beam_idx = bv;
            step();
        end
        cw.i_data_vld = 1'b0;
        cw.i_beam_vld = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached, expected bench to finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [BW-1:0] va, vb, vc, vd, v3, v4, vf;
        va = {16{8'hA5}};
        vb = {8{16'h1234}};
        vc = {4{32'hC0FFEE01}};
        vd = {16{8'h3C}};
        v3 = {2{64'h0102030405060708}};
        v4 = {16{8'h77}};
        vf = {4{32'hDEADBEEF}};
        n_chk = 0;
        n_err = 0;

        //          ncyc start tv  en rdy tmo
        tbl[0]  = '{0,   0, 0, 0, 0, 0};
        tbl[1]  = '{10,  0, 0, 0, 0, 0};
        tbl[2]  = '{1,   1, 0, 1, 0, 0};
        tbl[3]  = '{69,  0, 0, 1, 0, 0};
        tbl[4]  = '{1,   0, 1, 0, 0, 0};
        tbl[5]  = '{1,   0, 1, 0, 0, 0};
        tbl[6]  = '{1,   0, 1, 0, 1, 0};
        tbl[7]  = '{1,   1, 0, 1, 0, 0};
        tbl[8]  = '{254, 0, 0, 1, 0, 0};
        tbl[9]  = '{1,   0, 0, 0, 0, 1};
        tbl[10] = '{5,   0, 1, 0, 0, 1};
        tbl[11] = '{1,   1, 0, 1, 0, 0};
        tbl[12] = '{1,   0, 1, 0, 0, 0};
        tbl[13] = '{1,   1, 0, 1, 0, 0};
        tbl[14] = '{1,   0, 1, 0, 0, 0};
        tbl[15] = '{2,   0, 1, 0, 1, 0};

        i_reset_n      = 1'b0;
        cw.i_start     = 1'b0;
        cw.i_cw_tvalid = 1'b0;
        cw.i_sym_sop   = 1'b0;
        cw.i_sym_idx   = '0;
        cw.i_data_vld  = 1'b0;
        cw.i_beam_idx  = '0;
        cw.i_beam_vld  = 1'b0;
        repeat (3) @(posedge i_clk);
        #1;
        i_reset_n = 1'b1;

        chk("rst_beam_idx", cw.o_beam_idx, '0);
        chk("rst_beam_miss", BW'(cw.o_err_beam_miss), '0);

        // preload / timeout / restart table
        for (int i = 0; i < 16; i++) begin
            cw.i_start     = tbl[i].start;
            cw.i_cw_tvalid = tbl[i].tvalid;
            for (int k = 0; k < tbl[i].ncyc; k++) begin
                step();
                cw.i_start = 1'b0;
            end
            chk($sformatf("pre%0d_cw_enable", i), BW'(cw.o_cw_enable), BW'(tbl[i].exp_en));
            chk($sformatf("pre%0d_ready", i), BW'(cw.o_ready), BW'(tbl[i].exp_rdy));
            chk($sformatf("pre%0d_err_timeout", i), BW'(cw.o_err_timeout), BW'(tbl[i].exp_tmo));
        end
        cw.i_cw_tvalid = 1'b0;

        // symbol 0, three RBGs with beam vectors ahead of each boundary
        base = load_tot;
        sop(8'd0);
        chk("s0_symb_clr", BW'(cw.o_symb_clr), BW'(1'b1));
        chk("s0_symb_1st", BW'(cw.o_symb_1st), BW'(1'b1));
        chk("s0_symb_idx", BW'(cw.o_symb_idx), BW'(8'd0));
        chk("s0_rbg_cnt0", BW'(cw.o_rbg_cnt), BW'(8'd0));
        drive_re(47, 10, va);
        chk("s0_1st_at_e1", BW'(cw.o_symb_1st), BW'(1'b1));
        chk("s0_clr_gone", BW'(cw.o_symb_clr), BW'(1'b0));
        drive_re(1, -1, '0);
        chk("e1p1_beam_a", cw.o_beam_idx, va);
        chk("e1p1_rbg_cnt", BW'(cw.o_rbg_cnt), BW'(8'd1));
        chk("e1p1_1st_low", BW'(cw.o_symb_1st), BW'(1'b0));
        chk("e1p1_no_load", BW'(cw.o_rbg_load), BW'(1'b0));
        drive_re(1, -1, '0);
        chk("e1p2_load", BW'(cw.o_rbg_load), BW'(1'b1));
        drive_re(46, 5, vb);
        drive_re(1, -1, '0);
        chk("e2p1_beam_b", cw.o_beam_idx, vb);
        chk("e2p1_rbg_cnt", BW'(cw.o_rbg_cnt), BW'(8'd2));
        drive_re(1, -1, '0);
        chk("e2p2_load", BW'(cw.o_rbg_load), BW'(1'b1));
        drive_re(47, 7, vc);
        chk("e3p1_beam_c", cw.o_beam_idx, vc);
        chk("e3p1_rbg_cnt", BW'(cw.o_rbg_cnt), BW'(8'd3));
        chk("s0_load_count", BW'(load_tot - base), BW'(2));
        chk("s0_no_miss", BW'(cw.o_err_beam_miss), BW'(1'b0));

        // symbol 5, no beam vector before the first boundary
        sop(8'd5);
        chk("s5_no_clr", BW'(cw.o_symb_clr), BW'(1'b0));
        chk("s5_symb_idx", BW'(cw.o_symb_idx), BW'(8'd5));
        drive_re(48, -1, vd);
        chk("miss_beam_hold", cw.o_beam_idx, vc);
        chk("miss_flag", BW'(cw.o_err_beam_miss), BW'(1'b1));
        chk("miss_rbg_cnt", BW'(cw.o_rbg_cnt), BW'(8'd1));
        drive_re(1, -1, '0);
        chk("miss_load", BW'(cw.o_rbg_load), BW'(1'b1));

        // beam vector coincident with the boundary is used there
        drive_re(47, 46, vd);
        chk("bypass_beam_d", cw.o_beam_idx, vd);
        chk("bypass_rbg_cnt", BW'(cw.o_rbg_cnt), BW'(8'd2));
        drive_re(1, -1, '0);
        chk("bypass_load", BW'(cw.o_rbg_load), BW'(1'b1));
        drive_re(47, 10, v3);
        chk("rbg3_cnt", BW'(cw.o_rbg_cnt), BW'(8'd3));
        drive_re(20, -1, '0);

        // sop mid-RBG at re_cnt 20
        base = load_tot;
        sop(8'd7);
        chk("abort_rbg_cnt", BW'(cw.o_rbg_cnt), BW'(8'd0));
        chk("abort_1st", BW'(cw.o_symb_1st), BW'(1'b1));
        chk("abort_symb_idx", BW'(cw.o_symb_idx), BW'(8'd7));
        drive_re(3, -1, '0);
        chk("abort_no_load", BW'(load_tot - base), BW'(0));

        // sop while a load is pending must suppress it
        drive_re(45, 10, v4);
        chk("pend_rbg_cnt", BW'(cw.o_rbg_cnt), BW'(8'd1));
        sop(8'd8);
        chk("pend_load_kill", BW'(cw.o_rbg_load), BW'(1'b0));
        chk("pend_rbg_cnt0", BW'(cw.o_rbg_cnt), BW'(8'd0));
        step();
        chk("pend_load_count", BW'(load_tot - base), BW'(0));

        // restart clears the beam-miss flag, then a full symbol
        cw.i_start = 1'b1;
        step();
        cw.i_start = 1'b0;
        chk("restart_miss_clr", BW'(cw.o_err_beam_miss), BW'(1'b0));
        chk("restart_1st_low", BW'(cw.o_symb_1st), BW'(1'b0));
        chk("restart_enable", BW'(cw.o_cw_enable), BW'(1'b1));
        cw.i_cw_tvalid = 1'b1;
        repeat (3) step();
        cw.i_cw_tvalid = 1'b0;
        chk("restart_ready", BW'(cw.o_ready), BW'(1'b1));

        base = load_tot;
        sop(8'd2);
        drive_re(RBG_NUM * RBG_CYC, 5, vf);
        chk("full_rbg_last", BW'(cw.o_rbg_cnt), BW'(8'd67));
        drive_re(100, -1, '0);
        chk("full_rbg_hold", BW'(cw.o_rbg_cnt), BW'(8'd67));
        chk("full_load_count", BW'(load_tot - base), BW'(67));
        chk("full_no_miss", BW'(cw.o_err_beam_miss), BW'(1'b0));
        chk("full_beam_f", cw.o_beam_idx, vf);

        // async reset in the middle of an RBG
        sop(8'd1);
        drive_re(20, 3, va);
        #2;
        i_reset_n = 1'b0;
        #1;
        chk("arst_ready", BW'(cw.o_ready), BW'(1'b0));
        chk("arst_symb_idx", BW'(cw.o_symb_idx), BW'(8'd0));
        chk("arst_rbg_cnt", BW'(cw.o_rbg_cnt), BW'(8'd0));
        chk("arst_beam_idx", cw.o_beam_idx, '0);
        chk("arst_1st", BW'(cw.o_symb_1st), BW'(1'b0));
        chk("arst_enable", BW'(cw.o_cw_enable), BW'(1'b0));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
